sdio_cmd: RTL and testbench

SD-domain command-line engine: serialises a 48-bit SD command frame onto the CMD pad, waits for and captures the card response (48-bit or 136-bit), checks CRC7/index/end bit, and reports completion and errors. It consumes the command fields held in the SD-domain register file. It produces the resp/resp_index/resp_crc, cmd_busy/cmd_fsm and command error/complete inputs that the register file reads back. It runs on sd_clk, one CMD bit per cycle.

---
 rtl/sdio_cmd.sv | 210 +++++++++++++++++++++
 tb/tb_sdio_cmd.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_cmd.sv
// SD command-line engine: serialises a 48-bit command frame on CMD, then captures
// and checks the 48-bit or 136-bit card response, one bit per sd_clk.
module sdio_cmd #(
  parameter int NCR_TIMEOUT = 64,
  parameter int NCC_CYCLES  = 8
) (
  input  logic         sd_clk,
  input  logic         rstn,
  input  logic         cmd_sd_rst,
  input  logic         cmd_start,
  input  logic [31:0]  cmd_argument,
  input  logic [5:0]   cmd_index,
  input  logic [1:0]   resp_type,
  input  logic         cmd_index_check,
  input  logic         cmd_crc_check,
  input  logic         pad_cmd_i,
  output logic         pad_cmd_o,
  output logic         pad_cmd_oe,
  output logic [119:0] resp,
  output logic [5:0]   resp_index,
  output logic [6:0]   resp_crc,
  output logic         cmd_busy,
  output logic [3:0]   cmd_fsm,
  output logic         cmd_complete,
  output logic         cmd_timeout_err,
  output logic         cmd_crc_err,
  output logic         cmd_end_err,
  output logic         cmd_index_err
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_TX   = 4'd1,
    ST_WAIT = 4'd2,
    ST_RX   = 4'd3,
    ST_GAP  = 4'd4
  } state_t;

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic [6:0]  crc_r;
  logic [39:0] tx_shift_r;
  logic [5:0]  idx_r;
  logic [1:0]  rtype_r;
  logic        idx_chk_r;
  logic        crc_chk_r;
  logic        long_s;
  logic        rx_last_s;

  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    crc7_next = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign long_s    = (rtype_r == 2'd2);
  assign rx_last_s = (cnt_r == (long_s ? 8'd135 : 8'd47));
  assign cmd_fsm   = state_r;
  assign cmd_busy  = (state_r != ST_IDLE);

  // Command state machine: one CMD bit transmitted or received per cycle.
  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      state_r         <= ST_IDLE;
      cnt_r           <= 8'd0;
      crc_r           <= 7'd0;
      tx_shift_r      <= 40'd0;
      idx_r           <= 6'd0;
      rtype_r         <= 2'd0;
      idx_chk_r       <= 1'b0;
      crc_chk_r       <= 1'b0;
      pad_cmd_o       <= 1'b1;
      pad_cmd_oe      <= 1'b0;
      resp            <= 120'd0;
      resp_index      <= 6'd0;
      resp_crc        <= 7'd0;
      cmd_complete    <= 1'b0;
      cmd_timeout_err <= 1'b0;
      cmd_crc_err     <= 1'b0;
      cmd_end_err     <= 1'b0;
      cmd_index_err   <= 1'b0;
    end else if (cmd_sd_rst) begin
      state_r         <= ST_IDLE;
      cnt_r           <= 8'd0;
      crc_r           <= 7'd0;
      tx_shift_r      <= 40'd0;
      idx_r           <= 6'd0;
      rtype_r         <= 2'd0;
      idx_chk_r       <= 1'b0;
      crc_chk_r       <= 1'b0;
      pad_cmd_o       <= 1'b1;
      pad_cmd_oe      <= 1'b0;
      resp            <= 120'd0;
      resp_index      <= 6'd0;
      resp_crc        <= 7'd0;
      cmd_complete    <= 1'b0;
      cmd_timeout_err <= 1'b0;
      cmd_crc_err     <= 1'b0;
      cmd_end_err     <= 1'b0;
      cmd_index_err   <= 1'b0;
    end else begin
      cmd_complete <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_start) begin
            tx_shift_r      <= {2'b01, cmd_index, cmd_argument};
            idx_r           <= cmd_index;
            rtype_r         <= resp_type;
            idx_chk_r       <= cmd_index_check;
            crc_chk_r       <= cmd_crc_check;
            resp            <= 120'd0;
            resp_index      <= 6'd0;
            resp_crc        <= 7'd0;
            cmd_timeout_err <= 1'b0;
            cmd_crc_err     <= 1'b0;
            cmd_end_err     <= 1'b0;
            cmd_index_err   <= 1'b0;
            cnt_r           <= 8'd0;
            crc_r           <= 7'd0;
            state_r         <= ST_TX;
          end
        end
        ST_TX: begin
          cnt_r <= cnt_r + 8'd1;
          if (cnt_r < 8'd40) begin
            pad_cmd_oe <= 1'b1;
            pad_cmd_o  <= tx_shift_r[39];
            tx_shift_r <= {tx_shift_r[38:0], 1'b0};
            crc_r      <= crc7_next(crc_r, tx_shift_r[39]);
          end else if (cnt_r < 8'd47) begin
            pad_cmd_o <= crc_r[6];
            crc_r     <= {crc_r[5:0], 1'b0};
          end else if (cnt_r == 8'd47) begin
            pad_cmd_o <= 1'b1;
          end else begin
            pad_cmd_oe <= 1'b0;
            pad_cmd_o  <= 1'b1;
            cnt_r      <= 8'd0;
            if (rtype_r == 2'd0) begin
              cmd_complete <= 1'b1;
              state_r      <= ST_GAP;
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!pad_cmd_i) begin
            // Start bit is 0, so it leaves the zero-seeded CRC unchanged.
            cnt_r   <= 8'd1;
            crc_r   <= 7'd0;
            state_r <= ST_RX;
          end else if (cnt_r == 8'(NCR_TIMEOUT - 1)) begin
            cmd_timeout_err <= 1'b1;
            cmd_complete    <= 1'b1;
            cnt_r           <= 8'd0;
            state_r         <= ST_GAP;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_RX: begin
          cnt_r <= cnt_r + 8'd1;
          if (rx_last_s) begin
            cmd_end_err   <= ~pad_cmd_i;
            cmd_crc_err   <= crc_chk_r & (crc_r != resp_crc);
            cmd_index_err <= idx_chk_r & ~long_s & (resp_index != idx_r);
            cmd_complete  <= 1'b1;
            cnt_r         <= 8'd0;
            state_r       <= ST_GAP;
          end else if (long_s) begin
            // Long response: reserved bits 1..7 are skipped, CRC covers content only.
            if (cnt_r >= 8'd8 && cnt_r <= 8'd127) begin
              resp  <= {resp[118:0], pad_cmd_i};
              crc_r <= crc7_next(crc_r, pad_cmd_i);
            end else if (cnt_r >= 8'd128) begin
              resp_crc <= {resp_crc[5:0], pad_cmd_i};
            end
          end else begin
            if (cnt_r <= 8'd39) begin
              crc_r <= crc7_next(crc_r, pad_cmd_i);
            end
            if (cnt_r >= 8'd2 && cnt_r <= 8'd7) begin
              resp_index <= {resp_index[4:0], pad_cmd_i};
            end else if (cnt_r >= 8'd8 && cnt_r <= 8'd39) begin
              resp <= {resp[118:0], pad_cmd_i};
            end else if (cnt_r >= 8'd40) begin
              resp_crc <= {resp_crc[5:0], pad_cmd_i};
            end
          end
        end
        ST_GAP: begin
          // The completion cycle counts as the first of the NCC idle cycles.
          if (cnt_r == 8'(NCC_CYCLES - 2)) begin
            cnt_r   <= 8'd0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          pad_cmd_oe <= 1'b0;
          pad_cmd_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdio_cmd.sv
// Self-checking bench for sdio_cmd: a card model drives CMD responses and a
// polynomial-division CRC7 reference predicts frames, fields and error flags.
module tb_sdio_cmd;

  logic         sd_clk = 1'b0;
  logic         rstn = 1'b0;
  logic         cmd_sd_rst = 1'b0;
  logic         cmd_start = 1'b0;
  logic [31:0]  cmd_argument = 32'd0;
  logic [5:0]   cmd_index = 6'd0;
  logic [1:0]   resp_type = 2'd0;
  logic         cmd_index_check = 1'b0;
  logic         cmd_crc_check = 1'b0;
  logic         pad_cmd_i = 1'b1;
  logic         pad_cmd_o;
  logic         pad_cmd_oe;
  logic [119:0] resp;
  logic [5:0]   resp_index;
  logic [6:0]   resp_crc;
  logic         cmd_busy;
  logic [3:0]   cmd_fsm;
  logic         cmd_complete;
  logic         cmd_timeout_err;
  logic         cmd_crc_err;
  logic         cmd_end_err;
  logic         cmd_index_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [136:0] obs_s;
  assign obs_s = {resp, resp_index, resp_crc, cmd_timeout_err, cmd_crc_err, cmd_end_err, cmd_index_err};

  sdio_cmd dut (
    .sd_clk(sd_clk), .rstn(rstn), .cmd_sd_rst(cmd_sd_rst), .cmd_start(cmd_start),
    .cmd_argument(cmd_argument), .cmd_index(cmd_index), .resp_type(resp_type),
    .cmd_index_check(cmd_index_check), .cmd_crc_check(cmd_crc_check),
    .pad_cmd_i(pad_cmd_i), .pad_cmd_o(pad_cmd_o), .pad_cmd_oe(pad_cmd_oe),
    .resp(resp), .resp_index(resp_index), .resp_crc(resp_crc), .cmd_busy(cmd_busy),
    .cmd_fsm(cmd_fsm), .cmd_complete(cmd_complete), .cmd_timeout_err(cmd_timeout_err),
    .cmd_crc_err(cmd_crc_err), .cmd_end_err(cmd_end_err), .cmd_index_err(cmd_index_err)
  );

  always #5 sd_clk = ~sd_clk;

  // CRC7 as the remainder of msg(x)*x^7 divided by x^7+x^3+1 (msg in the low n bits).
  function automatic logic [6:0] crc7_ref(input logic [119:0] msg, input int n);
    logic [126:0] w;
    w = {msg, 7'b0};
    for (int i = n + 6; i >= 7; i--) begin
      if (w[i]) w[i -: 8] = w[i -: 8] ^ 8'h89;
    end
    return w[6:0];
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, crc7_ref(120'(m), 40), 1'b1};
  endfunction

  function automatic logic [47:0] resp48(input logic [5:0] idx, input logic [31:0] content);
    logic [39:0] m;
    m = {2'b00, idx, content};
    return {m, crc7_ref(120'(m), 40), 1'b1};
  endfunction

  function automatic logic [136:0] exp_vec(input logic [119:0] r, input logic [5:0] i,
      input logic [6:0] c, input logic t, input logic ce, input logic ee, input logic ie);
    return {r, i, c, t, ce, ee, ie};
  endfunction

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  // Launches a command, scrambles the register inputs and pokes cmd_start during TX.
  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
      input logic ichk, input logic cchk, output logic [47:0] frame, output int oe_bad,
      output int busy_n);
    int poke;
    poke = $urandom_range(2, 40);
    cmd_index = idx; cmd_argument = arg; resp_type = rt;
    cmd_index_check = ichk; cmd_crc_check = cchk; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    cmd_argument = $urandom; cmd_index = 6'($urandom); resp_type = 2'($urandom);
    cmd_index_check = 1'($urandom); cmd_crc_check = 1'($urandom);
    frame = 48'd0; oe_bad = 0; busy_n = cmd_busy ? 1 : 0;
    for (int k = 0; k < 48; k++) begin
      cmd_start = (k == poke);
      tick();
      frame = {frame[46:0], pad_cmd_o};
      if (pad_cmd_oe !== 1'b1) oe_bad++;
      if (cmd_busy === 1'b1) busy_n++;
    end
    cmd_start = 1'b0;
    tick();
    if (pad_cmd_oe !== 1'b0) oe_bad++;
    if (cmd_busy === 1'b1) busy_n++;
  endtask

  task automatic drive_resp(input logic [135:0] bits, input int len, input int dly);
    pad_cmd_i = 1'b1;
    repeat (dly) tick();
    for (int i = len - 1; i >= 0; i--) begin
      pad_cmd_i = bits[i];
      tick();
    end
    pad_cmd_i = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && cmd_busy !== 1'b0; i++) tick();
    tests_run++;
    if (cmd_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s idle: busy=%b required 0", name, cmd_busy);
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({pad_cmd_o, pad_cmd_oe, cmd_busy, cmd_fsm, cmd_complete} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0}
        || obs_s !== 137'd0) begin
      tests_failed++;
      $display("FAIL reset: o=%b oe=%b busy=%b fsm=%0d cpl=%b vec=%h", pad_cmd_o, pad_cmd_oe,
               cmd_busy, cmd_fsm, cmd_complete, obs_s);
    end
  endtask

  task automatic test_cmd0();
    logic [47:0] f; int oe_bad; int busy_n;
    send_cmd(6'd0, 32'd0, 2'd0, 1'b0, 1'b0, f, oe_bad, busy_n);
    tests_run++;
    if (f !== 48'h400000000095 || oe_bad != 0) begin
      tests_failed++;
      $display("FAIL cmd0 frame: got %h oe_bad=%0d required 400000000095", f, oe_bad);
    end
    tests_run++;
    if (cmd_complete !== 1'b1 || obs_s !== 137'd0) begin
      tests_failed++;
      $display("FAIL cmd0 complete: cpl=%b vec=%h required cpl=1 vec=0", cmd_complete, obs_s);
    end
    for (int i = 0; i < 20 && cmd_busy === 1'b1; i++) begin
      tick();
      if (cmd_busy === 1'b1) busy_n++;
    end
    tests_run++;
    if (busy_n != 56) begin
      tests_failed++;
      $display("FAIL cmd0 busy: got %0d cycles required 56", busy_n);
    end
  endtask

  task automatic test_cmd8();
    logic [47:0] f; int oe_bad; int busy_n;
    logic [47:0] rf [4];
    logic        cc [4];
    logic [3:0]  fl [4];
    rf[0] = 48'h08000001AA13; cc[0] = 1'b1; fl[0] = 4'b0000;
    rf[1] = 48'h08000001AA15; cc[1] = 1'b1; fl[1] = 4'b0100;
    rf[2] = 48'h08000001AA15; cc[2] = 1'b0; fl[2] = 4'b0000;
    rf[3] = 48'h08000001AA12; cc[3] = 1'b1; fl[3] = 4'b0010;
    for (int v = 0; v < 4; v++) begin
      send_cmd(6'd8, 32'h000001AA, 2'd1, 1'b1, cc[v], f, oe_bad, busy_n);
      tests_run++;
      if (f !== 48'h48000001AA87 || oe_bad != 0) begin
        tests_failed++;
        $display("FAIL cmd8 frame v%0d: got %h oe_bad=%0d required 48000001AA87", v, f, oe_bad);
      end
      drive_resp(136'(rf[v]), 48, 3);
      tests_run++;
      if (cmd_complete !== 1'b1 ||
          obs_s !== exp_vec(120'h1AA, 6'd8, rf[v][7:1], fl[v][3], fl[v][2], fl[v][1], fl[v][0])) begin
        tests_failed++;
        $display("FAIL cmd8 resp v%0d: cpl=%b vec=%h required cpl=1 flags=%b crc=%h", v,
                 cmd_complete, obs_s, fl[v], rf[v][7:1]);
      end
      wait_idle("cmd8");
    end
    send_cmd(6'd8, 32'h000001AA, 2'd1, 1'b1, 1'b1, f, oe_bad, busy_n);
    drive_resp(136'(resp48(6'd9, 32'h1AA)), 48, 0);
    tests_run++;
    if (cmd_complete !== 1'b1 || cmd_index_err !== 1'b1 || cmd_crc_err !== 1'b0 || resp_index !== 6'd9) begin
      tests_failed++;
      $display("FAIL cmd8 index: cpl=%b idx_err=%b crc_err=%b idx=%0d required 1 1 0 9",
               cmd_complete, cmd_index_err, cmd_crc_err, resp_index);
    end
    wait_idle("cmd8 index");
  endtask

  task automatic test_random48();
    logic [47:0] f, rf; int oe_bad; int busy_n;
    logic [5:0] idx, ridx; logic [31:0] arg, content; logic [1:0] rt;
    logic ichk, cchk; int kind; logic [136:0] ev;
    for (int it = 0; it < 10; it++) begin
      idx = 6'($urandom); arg = $urandom; content = $urandom;
      rt = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3;
      ichk = 1'($urandom); cchk = 1'($urandom); kind = $urandom_range(0, 3);
      ridx = (kind == 3) ? (idx ^ 6'(1 << $urandom_range(0, 5))) : idx;
      rf = resp48(ridx, content);
      if (kind == 1) rf[7:1] = rf[7:1] ^ 7'(1 << $urandom_range(0, 6));
      if (kind == 2) rf[0] = 1'b0;
      send_cmd(idx, arg, rt, ichk, cchk, f, oe_bad, busy_n);
      tests_run++;
      if (f !== cmd_frame(idx, arg) || oe_bad != 0) begin
        tests_failed++;
        $display("FAIL rand frame %0d: got %h required %h oe_bad=%0d", it, f, cmd_frame(idx, arg), oe_bad);
      end
      drive_resp(136'(rf), 48, $urandom_range(0, 30));
      ev = exp_vec(120'(content), ridx, rf[7:1], 1'b0,
                   cchk && (rf[7:1] != crc7_ref(120'({2'b00, ridx, content}), 40)),
                   rf[0] == 1'b0, ichk && (ridx != idx));
      tests_run++;
      if (cmd_complete !== 1'b1 || obs_s !== ev) begin
        tests_failed++;
        $display("FAIL rand resp %0d: cpl=%b got %h required %h", it, cmd_complete, obs_s, ev);
      end
      wait_idle("rand");
      tests_run++;
      if (cmd_complete !== 1'b0 || obs_s !== ev) begin
        tests_failed++;
        $display("FAIL rand hold %0d: cpl=%b got %h required %h", it, cmd_complete, obs_s, ev);
      end
    end
  endtask

  task automatic test_timeout();
    logic [47:0] f; int oe_bad; int busy_n;
    send_cmd(6'd8, 32'h1AA, 2'd1, 1'b1, 1'b1, f, oe_bad, busy_n);
    pad_cmd_i = 1'b1;
    repeat (63) tick();
    tests_run++;
    if (cmd_complete !== 1'b0 || cmd_timeout_err !== 1'b0 || cmd_fsm !== 4'd2) begin
      tests_failed++;
      $display("FAIL timeout early: cpl=%b to=%b fsm=%0d required 0 0 2", cmd_complete, cmd_timeout_err, cmd_fsm);
    end
    tick();
    tests_run++;
    if (cmd_complete !== 1'b1 || obs_s !== exp_vec(120'd0, 6'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0)) begin
      tests_failed++;
      $display("FAIL timeout: cpl=%b vec=%h required cpl=1 timeout only", cmd_complete, obs_s);
    end
    wait_idle("timeout");
  endtask

  task automatic test_long();
    logic [47:0] f; int oe_bad; int busy_n;
    logic [119:0] content; logic [6:0] c; logic [135:0] bits;
    for (int it = 0; it < 2; it++) begin
      content = {24'h1D4144, $urandom, $urandom, $urandom};
      c = crc7_ref(content, 120);
      bits = {2'b00, 6'b111111, content, c, 1'b1};
      send_cmd(6'd2, 32'd0, 2'd2, 1'b1, 1'b1, f, oe_bad, busy_n);
      drive_resp(bits, 136, $urandom_range(0, 10));
      tests_run++;
      if (cmd_complete !== 1'b1 || obs_s !== exp_vec(content, 6'd0, c, 1'b0, 1'b0, 1'b0, 1'b0)) begin
        tests_failed++;
        $display("FAIL long %0d: cpl=%b got %h required %h", it, cmd_complete, obs_s,
                 exp_vec(content, 6'd0, c, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      wait_idle("long");
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] f; int oe_bad; int busy_n; logic [5:0] idx; logic [31:0] arg;
    send_cmd(6'd0, 32'd0, 2'd0, 1'b0, 1'b0, f, oe_bad, busy_n);
    repeat (6) tick();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    tests_run++;
    if (cmd_fsm !== 4'd0) begin
      tests_failed++;
      $display("FAIL b2b early start: fsm=%0d required 0", cmd_fsm);
    end
    idx = 6'($urandom); arg = $urandom;
    send_cmd(idx, arg, 2'd0, 1'b0, 1'b0, f, oe_bad, busy_n);
    tests_run++;
    if (f !== cmd_frame(idx, arg) || cmd_complete !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b second: got %h cpl=%b required %h cpl=1", f, cmd_complete, cmd_frame(idx, arg));
    end
    wait_idle("b2b");
  endtask

  task automatic test_resets();
    logic [47:0] f; int oe_bad; int busy_n; logic [119:0] content; logic [135:0] bits;
    content = {$urandom, $urandom, $urandom, 24'hA5A5A5};
    bits = {2'b00, 6'b111111, content, crc7_ref(content, 120), 1'b1};
    send_cmd(6'd2, 32'd0, 2'd2, 1'b1, 1'b1, f, oe_bad, busy_n);
    for (int i = 135; i >= 76; i--) begin
      pad_cmd_i = bits[i];
      tick();
    end
    pad_cmd_i = 1'b1;
    cmd_sd_rst = 1'b1;
    tick();
    cmd_sd_rst = 1'b0;
    tests_run++;
    if ({cmd_fsm, cmd_busy, pad_cmd_oe, pad_cmd_o, cmd_complete} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b0}
        || obs_s !== 137'd0) begin
      tests_failed++;
      $display("FAIL sd_rst: fsm=%0d oe=%b o=%b vec=%h required idle, zero", cmd_fsm, pad_cmd_oe, pad_cmd_o, obs_s);
    end
    cmd_index = 6'd17; cmd_argument = $urandom; resp_type = 2'd1; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    repeat (5) tick();
    #2 rstn = 1'b0;
    #1;
    tests_run++;
    if ({cmd_fsm, pad_cmd_oe, pad_cmd_o} !== {4'd0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL rstn async: fsm=%0d oe=%b o=%b required 0 0 1", cmd_fsm, pad_cmd_oe, pad_cmd_o);
    end
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (cmd_fsm !== 4'd0 || pad_cmd_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstn hold: fsm=%0d oe=%b required 0 0", cmd_fsm, pad_cmd_oe);
    end
  endtask

  initial begin
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    test_reset();
    test_cmd0();
    test_cmd8();
    test_random48();
    test_timeout();
    test_long();
    test_back_to_back();
    test_resets();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
